// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel-in / window-out bundle for sobel_window_gen.
// Carries sof only when SOBEL_WIN_SOF_EN is defined.
interface sobel_window_gen_if #(parameter int IMG_W = 100, IMG_H = 100, PIX_W = 8);
  logic [PIX_W-1:0] pix_in;
  logic pix_valid;
`ifdef SOBEL_WIN_SOF_EN
  logic sof;
`endif
  logic [3*PIX_W-1:0] row1, row2, row3;
  logic win_valid, frame_done;
  logic [$clog2(IMG_H)-1:0] win_row;
  logic [$clog2(IMG_W)-1:0] win_col;
  modport master(
`ifdef SOBEL_WIN_SOF_EN
    output sof,
`endif
    output pix_in, pix_valid,
    input row1, row2, row3, win_valid, frame_done, win_row, win_col);
  modport slave(
`ifdef SOBEL_WIN_SOF_EN
    input sof,
`endif
    input pix_in, pix_valid,
    output row1, row2, row3, win_valid, frame_done, win_row, win_col);
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to 3x3 windows (left column in MSBs) for sobel.
// SOBEL_WIN_SOF_EN adds sof: an accepted pixel with sof is taken as pixel (0,0).
module sobel_window_gen #(parameter int IMG_W = 100, IMG_H = 100, PIX_W = 8) (
  input logic clk,
  input logic rst_n,
  sobel_window_gen_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [PIX_W-1:0] lb_a [IMG_W];
  logic [PIX_W-1:0] lb_b [IMG_W];
  logic [CW-1:0] col, cc;
  logic [RW-1:0] row, rr;
  logic [3*PIX_W-1:0] top, mid, bot, top_n, mid_n, bot_n;
  logic sof_hit, emit, col_last, row_last;
`ifdef SOBEL_WIN_SOF_EN
  assign sof_hit = s.pix_valid && s.sof;
`else
  assign sof_hit = 1'b0;
`endif
  // cc/rr: effective position of the current pixel, forced to (0,0) on resync
  always_comb begin
    cc = sof_hit ? '0 : col;
    rr = sof_hit ? '0 : row;
    col_last = cc == CW'(IMG_W - 1);
    row_last = rr == RW'(IMG_H - 1);
    top_n = {top[2*PIX_W-1:0], lb_b[cc]};
    mid_n = {mid[2*PIX_W-1:0], lb_a[cc]};
    bot_n = {bot[2*PIX_W-1:0], s.pix_in};
    emit = s.pix_valid && rr >= RW'(2) && cc >= CW'(2);
  end
  // line buffers are not reset; the r>=2 gate keeps stale contents out of windows
  always_ff @(posedge clk) begin
    if (s.pix_valid) begin
      lb_b[cc] <= lb_a[cc];
      lb_a[cc] <= s.pix_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      top <= '0;
      mid <= '0;
      bot <= '0;
      s.row1 <= '0;
      s.row2 <= '0;
      s.row3 <= '0;
      s.win_row <= '0;
      s.win_col <= '0;
      s.win_valid <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      s.win_valid <= emit;
      s.frame_done <= emit && row_last && col_last;
      if (s.pix_valid) begin
        top <= top_n;
        mid <= mid_n;
        bot <= bot_n;
        col <= col_last ? '0 : cc + 1'b1;
        row <= col_last ? (row_last ? '0 : rr + 1'b1) : rr;
      end
      if (emit) begin
        s.row1 <= top_n;
        s.row2 <= mid_n;
        s.row3 <= bot_n;
        s.win_row <= rr - 1'b1;
        s.win_col <= cc - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: 4x4 random-stimulus bench against an image-array window model.
module tb_sobel_window_gen;
  localparam int W = 4, H = 4, P = 8;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  sobel_window_gen_if #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) bus();
  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut(.clk(clk), .rst_n(rst_n), .s(bus));
  int errors = 0, checks = 0, n_win = 0, n_fd = 0, w0, f0;
  bit run = 0;
  logic [P-1:0] img [H][W];
  int mr, mc;
  logic e_v, e_fd;
  logic [3*P-1:0] e_r1, e_r2, e_r3;
  logic [1:0] e_wr, e_wc;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_clear();
    mr = 0; mc = 0; e_v = 0; e_fd = 0;
    e_r1 = 0; e_r2 = 0; e_r3 = 0; e_wr = 0; e_wc = 0;
  endtask

  // one clock: drive inputs, predict from the image array, advance model after the edge
  task automatic cyc(bit v, logic [P-1:0] p, bit s = 0);
    bit nv, nfd;
    logic [3*P-1:0] n1, n2, n3;
    logic [1:0] nwr, nwc;
    nv = 0; nfd = 0; n1 = 0; n2 = 0; n3 = 0; nwr = 0; nwc = 0;
    bus.pix_valid = v;
    bus.pix_in = p;
`ifdef SOBEL_WIN_SOF_EN
    bus.sof = s;
`endif
    if (v) begin
      if (s) begin
        img[0][0] = p;
        mr = 0; mc = 1;
      end else begin
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
          nv = 1;
          nfd = (mr == H - 1 && mc == W - 1);
          n1 = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc]};
          n2 = {img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc]};
          n3 = {img[mr][mc-2], img[mr][mc-1], img[mr][mc]};
          nwr = 2'(mr - 1);
          nwc = 2'(mc - 1);
        end
        mc++;
        if (mc == W) begin
          mc = 0; mr++;
          if (mr == H) mr = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    e_v = nv; e_fd = nfd;
    if (nv) begin
      e_r1 = n1; e_r2 = n2; e_r3 = n3; e_wr = nwr; e_wc = nwc;
    end
    bus.pix_valid = 0;
`ifdef SOBEL_WIN_SOF_EN
    bus.sof = 0;
`endif
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_row1"}, bus.row1, 0);
    chk({tag, "_row2"}, bus.row2, 0);
    chk({tag, "_row3"}, bus.row3, 0);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_win_rc"}, {bus.win_row, bus.win_col}, 0);
  endtask

  always @(negedge clk) if (run) begin
    chk("win_valid", bus.win_valid, e_v);
    chk("frame_done", bus.frame_done, e_fd);
    chk("row1", bus.row1, e_r1);
    chk("row2", bus.row2, e_r2);
    chk("row3", bus.row3, e_r3);
    chk("win_row", bus.win_row, e_wr);
    chk("win_col", bus.win_col, e_wc);
    if (bus.win_valid) n_win++;
    if (bus.frame_done) n_fd++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.pix_valid = 0;
    bus.pix_in = 0;
`ifdef SOBEL_WIN_SOF_EN
    bus.sof = 0;
`endif
    model_clear();
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    run = 1;
    // continuous ramp frame with hand-computed first window
    w0 = n_win; f0 = n_fd;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(16 * (i / 4) + i % 4));
      if (i == 10) begin
        chk("lit_model_row1", e_r1, 24'h000102);
        chk("lit_row1", bus.row1, 24'h000102);
        chk("lit_row2", bus.row2, 24'h101112);
        chk("lit_row3", bus.row3, 24'h202122);
        chk("lit_win_rc", {bus.win_row, bus.win_col}, 4'b0101);
        chk("lit_win_valid", bus.win_valid, 1);
      end
    end
    cyc(0, 0);
    chk("ramp_windows", n_win - w0, 4);
    chk("ramp_frame_done", n_fd - f0, 1);
    // same frame with random idle gaps
    w0 = n_win; f0 = n_fd;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 2) == 0) cyc(0, 8'($urandom));
      cyc(1, 8'(16 * (i / 4) + i % 4));
    end
    cyc(0, 0);
    chk("gap_windows", n_win - w0, 4);
    chk("gap_frame_done", n_fd - f0, 1);
    // two random frames back to back
    w0 = n_win; f0 = n_fd;
    for (int i = 0; i < 32; i++) cyc(1, 8'($urandom));
    cyc(0, 0);
    chk("b2b_windows", n_win - w0, 8);
    chk("b2b_frame_done", n_fd - f0, 2);
    // reset mid-frame after pixel (2,3)
    for (int i = 0; i < 12; i++) cyc(1, 8'($urandom));
    rst_n = 0;
    #1;
    chk_zero("async_rst");
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
    w0 = n_win; f0 = n_fd;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(8'h40 + 16 * (i / 4) + i % 4));
      if (i == 9) chk("post_rst_no_early_win", n_win - w0, 0);
    end
    cyc(0, 0);
    chk("post_rst_windows", n_win - w0, 4);
    // random frames with random gaps
    w0 = n_win; f0 = n_fd;
    for (int i = 0; i < 80; i++) begin
      while ($urandom_range(0, 3) == 0) cyc(0, 8'($urandom));
      cyc(1, 8'($urandom));
    end
    cyc(0, 0);
    chk("rand_windows", n_win - w0, 20);
    chk("rand_frame_done", n_fd - f0, 5);
`ifdef SOBEL_WIN_SOF_EN
    // sof on the 6th pixel restarts framing
    w0 = n_win; f0 = n_fd;
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom));
    cyc(1, 8'($urandom), 1);
    chk("sof_no_window", bus.win_valid, 0);
    for (int i = 1; i < 16; i++) cyc(1, 8'($urandom));
    cyc(0, 0);
    chk("sof_windows", n_win - w0, 4);
    chk("sof_frame_done", n_fd - f0, 1);
`endif
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Raster-to-window front end for the `sobel` kernel: accepts a row-major 8-bit pixel stream, one pixel per cycle max.
- Produces the 3x3 neighbourhood of every interior pixel on `row1`/`row2`/`row3`, in the exact packing `sobel` consumes.
- Sits between the image source (DMA/file reader) and `sobel`; replaces the software windowing loop used in simulation.

Parameters:
- IMG_W, 100, image width in pixels (>=3).
- IMG_H, 100, image height in pixels (>=3).
- PIX_W, 8, bits per pixel; row buses are 3*PIX_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in accepted this cycle; no backpressure, source may insert gaps.
- row1  out  3*PIX_W  upper window row {left,centre,right}, left in MSBs.
- row2  out  3*PIX_W  middle window row, same packing.
- row3  out  3*PIX_W  lower window row, same packing.
- win_valid  out  1  window on row1..3 is new this cycle (1-cycle pulse).
- win_row  out  $clog2(IMG_H)  row of window centre.
- win_col  out  $clog2(IMG_W)  column of window centre.
- frame_done  out  1  pulses with the last window of a frame.

Behaviour:
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 track the position of the next accepted pixel.
  - col advances on each accepted pixel; it wraps to 0 and increments row at IMG_W-1.
  - row wraps to 0 after (IMG_H-1, IMG_W-1), so back-to-back frames need no gap.
- Line buffers: lb_a holds row r-1 and lb_b holds row r-2, each IMG_W x PIX_W.
  - On accept at column c: read t=lb_b[c], m=lb_a[c], b=pix_in.
  - Then write lb_b[c]<=lb_a[c] and lb_a[c]<=pix_in, both in the same cycle.
  - Read-before-write semantics are required.
- Column shift registers: three 3-entry regs (top/mid/bot).
  - Shift only on accept, new sample entering the right (LSB) slot.
  - Shift registers are not cleared at line start; stale left columns are harmless because windows are gated by c>=2.
- Window emit: an accepted pixel at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1).
  - Next rising edge: row1={t[c-2],t[c-1],t[c]}, row2 = same from mid, row3 = same from bot.
  - Same edge: win_row=r-1, win_col=c-1, win_valid=1.
- Latency: exactly 1 clk from the completing pixel's accept edge to win_valid.
- Window rate:
  - No window for pixels in row 0/1 or col 0/1.
  - Exactly (IMG_W-2)*(IMG_H-2) windows per frame; 9604 at default sizes.
- Output hold: when win_valid=0, row1..3, win_row and win_col hold their last values. win_valid and frame_done are 0 whenever no window is emitted.
- frame_done=1 together with win_valid for the window from pixel (IMG_H-1, IMG_W-1), i.e. centre (IMG_H-2, IMG_W-2).
- Idle: pix_valid=0 changes no state except clearing the win_valid/frame_done pulses.
- Reset (async assert, any time incl. mid-frame):
  - Values: counters=0, shift regs=0, row1..3=0, win_row=win_col=0, win_valid=0, frame_done=0.
  - Line buffer RAM is not reset; stale data is never emitted because of the r>=2 gate.
  - The first accepted pixel after release is (0,0).
- Widths: pure data movement, no arithmetic on pixel values. Counter compares use full-width equality to IMG_W-1 / IMG_H-1.

Optional Feature:
- SOBEL_WIN_SOF_EN
- Defined:
  - Adds input port `sof` (1 bit).
  - pix_valid&&sof treats pix_in as pixel (0,0): counters reload to col=1,row=0 after the accept, and no window is emitted from that pixel.
  - sof without pix_valid is ignored.
  - Resynchronises a source that drops or adds pixels.
- Undefined: port absent; framing is purely counter-based.

Test Plan:
- IMG_W=IMG_H=4, pix=16*r+c, pix_valid held high:
  - The cycle after pixel (2,2) gives row1=0x000102, row2=0x101112, row3=0x202122, win_row=1, win_col=1, win_valid=1.
  - Exactly 4 windows per frame; frame_done with centre (2,2).
- Default 100x100 image from bicho.bin, continuous valid:
  - 9604 windows; each row1..3 matches data[ii-1..ii+1][jj-1..jj+1].
  - Feeding these windows to `sobel` reproduces sobel.bin interior values.
- Same 4x4 image with pix_valid toggling 1-0-0-1 randomly:
  - Identical window sequence to the continuous case.
  - win_valid never asserted on idle-following cycles without an accept.
- Assert rst_n=0 after pixel (2,3) of a 4x4 frame:
  - Outputs are 0 immediately (async).
  - After release, a fresh frame yields its first window only after pixel (2,2) of the new frame.
- Two 4x4 frames back-to-back with no gap: 8 windows and 2 frame_done pulses; second frame's windows contain no first-frame pixels.
- SOBEL_WIN_SOF_EN defined: inject sof at the 6th pixel of a frame.
  - No window from that pixel.
  - Next windows are computed as if that pixel were (0,0); first window follows the new frame's pixel (2,2).
